// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register, next-PC select and return-address stack.
// Optional feature macro: PC_SEQ_DELAY_SLOT_EN (MIPS branch delay slot; adds
// the DELAY state and the pending-target register, link becomes pc + 8).
module pc_sequencer #(
  parameter int          ADDR_W    = 32,            // >= 28
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          RAS_DEPTH = 4              // power of two, >= 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [31:0]       instr,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              jump_register,
  input  logic [31:0]       register_value,
  input  logic              link,
  input  logic              is_return,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ret_mispredict,
  output logic              addr_misaligned
);

  localparam int                PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
  localparam logic [PTR_W:0]    RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] pcReg, pcD;
  logic [ADDR_W-1:0] pcPlus4, linkAddr;
  logic [ADDR_W-1:0] brTarget, jTarget, jrTarget, target;
  logic              redirect, active;
  logic              doJr, doRet, doPush;

  // Opcode bits and the upper rs bits never feed the address math.
  logic unusedBits;
  assign unusedBits = ^{instr[31:26], register_value};

  // ---------------------------------------------------------------- targets
  assign pcPlus4  = pcReg + ADDR_W'(4);
  assign brTarget = pcPlus4 + {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign jrTarget = ADDR_W'({register_value[31:2], 2'b00});

  // Region bits above 28 only exist when the address is wider than 28 bits.
  generate
    if (ADDR_W > 28) begin : gJRegion
      assign jTarget = {pcPlus4[ADDR_W-1:28], instr[25:0], 2'b00};
    end else begin : gJFlat
      assign jTarget = {instr[25:0], 2'b00};
    end
  endgenerate

  // jump wins over a taken branch; jr uses the word-aligned rs value.
  assign redirect = jump | (branch & branch_taken);
  assign target   = jump ? (jump_register ? jrTarget : jTarget) : brTarget;

`ifdef PC_SEQ_DELAY_SLOT_EN
  // ------------------------------------------------------ delay-slot FSM
  typedef enum logic {NORMAL, DELAY} state_t;
  state_t            stateQ, stateD;
  logic [ADDR_W-1:0] pendingQ, pendingD;

  assign linkAddr = pcReg + ADDR_W'(8);
  // The delay-slot instruction's controls are not acted on.
  assign active   = !stall && (stateQ == NORMAL);

  // State, PC and pending-target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= NORMAL;
      pcReg    <= RST_PC;
      pendingQ <= '0;
    end else begin
      stateQ   <= stateD;
      pcReg    <= pcD;
      pendingQ <= pendingD;
    end
  end

  // Next state: a redirect first fetches the delay slot, then the target.
  always_comb begin
    stateD   = stateQ;
    pcD      = pcReg;
    pendingD = pendingQ;
    if (!stall) begin
      case (stateQ)
        NORMAL: begin
          pcD = pcPlus4;
          if (redirect) begin
            stateD   = DELAY;
            pendingD = target;
          end
        end
        DELAY: begin
          pcD    = pendingQ;
          stateD = NORMAL;
        end
        default: stateD = NORMAL;
      endcase
    end
  end
`else
  // ------------------------------------------------- no delay slot
  assign linkAddr = pcPlus4;
  assign active   = !stall;

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcReg <= RST_PC;
    else        pcReg <= pcD;
  end

  // Redirect takes effect on the sampling edge.
  always_comb begin
    pcD = pcReg;
    if (!stall) pcD = redirect ? target : pcPlus4;
  end
`endif

  // ------------------------------------------------------------------ RAS
  logic [ADDR_W-1:0] rasMem [RAS_DEPTH];
  logic [PTR_W-1:0]  wrPtr, wrPtrD, topIdx, popPtr, wrIdx;
  logic [PTR_W:0]    rasCnt, rasCntD, popCnt;
  logic              wrEn, retMissD, misalignD, retMissQ, misalignQ;

  assign doJr   = active & jump & jump_register;
  assign doRet  = doJr & is_return;
  assign doPush = active & link;
  assign topIdx = wrPtr - 1'b1;
  assign misalignD = doJr & (|register_value[1:0]);

  // Pop/compare first, then push into the slot the pop just freed.
  always_comb begin
    popPtr   = wrPtr;
    popCnt   = rasCnt;
    retMissD = 1'b0;
    if (doRet) begin
      if (rasCnt == '0) begin
        retMissD = 1'b1;
      end else begin
        retMissD = (rasMem[topIdx] != jrTarget);
        popPtr   = topIdx;
        popCnt   = rasCnt - 1'b1;
      end
    end
    wrPtrD  = popPtr;
    rasCntD = popCnt;
    wrEn    = doPush;
    wrIdx   = popPtr;
    if (doPush) begin
      // When full, the write slot is the oldest entry; the count saturates.
      wrPtrD = popPtr + 1'b1;
      if (popCnt != RAS_FULL) rasCntD = popCnt + 1'b1;
    end
  end

  // Stack storage, pointers and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) rasMem[i] <= '0;
      wrPtr     <= '0;
      rasCnt    <= '0;
      retMissQ  <= 1'b0;
      misalignQ <= 1'b0;
    end else begin
      if (wrEn) rasMem[wrIdx] <= linkAddr;
      wrPtr     <= wrPtrD;
      rasCnt    <= rasCntD;
      retMissQ  <= retMissD;
      misalignQ <= misalignD;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign pc              = pcReg;
  assign pc_plus4        = pcPlus4;
  assign link_addr       = linkAddr;
  assign ras_empty       = (rasCnt == '0);
  assign ras_top         = ras_empty ? '0 : rasMem[topIdx];
  assign ret_mispredict  = retMissQ;
  assign addr_misaligned = misalignQ;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow PC_SEQ_DELAY_SLOT_EN.
module tb_pc_sequencer;

`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif
  localparam logic [31:0] LOFF = DLY ? 32'd8 : 32'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, branch, branch_taken, jump, jump_register, link, is_return;
  logic [31:0] instr, register_value;
  logic [31:0] pc, pc_plus4, link_addr, ras_top;
  logic        ras_empty, ret_mispredict, addr_misaligned;

  int nTests = 0;
  int nFail  = 0;

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0040_0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr), .branch(branch),
    .branch_taken(branch_taken), .jump(jump), .jump_register(jump_register),
    .register_value(register_value), .link(link), .is_return(is_return),
    .pc(pc), .pc_plus4(pc_plus4), .link_addr(link_addr), .ras_top(ras_top),
    .ras_empty(ras_empty), .ret_mispredict(ret_mispredict),
    .addr_misaligned(addr_misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    stall = 0; branch = 0; branch_taken = 0; jump = 0; jump_register = 0;
    link = 0; is_return = 0; instr = '0; register_value = '0;
  endtask

  // Plain j to a 0x004xxxxx address; leaves the sequencer in NORMAL at addr.
  task automatic gotoPc(input logic [31:0] a);
    idle(); jump = 1; instr = {6'b0, a[27:2]};
    step(); idle();
    if (DLY) step();
  endtask

  task automatic test_reset();
    idle();
    step(); step();
    nTests++; if (pc !== 32'h0040_0000) begin nFail++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0040_0000); end
    nTests++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin nFail++; $display("FAIL reset_ras: empty %b top %h exp 1 0", ras_empty, ras_top); end
    nTests++; if (ret_mispredict !== 1'b0 || addr_misaligned !== 1'b0) begin nFail++; $display("FAIL reset_pulses: %b %b exp 0 0", ret_mispredict, addr_misaligned); end
    rst_n = 1;
    nTests++; if (pc_plus4 !== 32'h0040_0004) begin nFail++; $display("FAIL reset_pc4: got %h exp %h", pc_plus4, 32'h0040_0004); end
    for (int i = 1; i <= 3; i++) begin
      step();
      nTests++; if (pc !== 32'h0040_0000 + 32'(4*i)) begin nFail++; $display("FAIL reset_seq%0d: got %h exp %h", i, pc, 32'h0040_0000 + 32'(4*i)); end
    end
  endtask

  task automatic test_branch();
    gotoPc(32'h0040_0010);
    nTests++; if (pc !== 32'h0040_0010) begin nFail++; $display("FAIL goto: got %h exp %h", pc, 32'h0040_0010); end
    branch = 1; branch_taken = 1; instr = 32'h0000_FFFC;
    step(); idle();
    nTests++; if (pc !== (DLY ? 32'h0040_0014 : 32'h0040_0004)) begin nFail++; $display("FAIL br_first: got %h exp %h", pc, DLY ? 32'h0040_0014 : 32'h0040_0004); end
    if (DLY) step();
    nTests++; if (pc !== 32'h0040_0004) begin nFail++; $display("FAIL br_target: got %h exp %h", pc, 32'h0040_0004); end
    branch = 1; branch_taken = 0; instr = 32'h0000_FFFC;
    step(); idle();
    nTests++; if (pc !== 32'h0040_0008) begin nFail++; $display("FAIL br_not_taken: got %h exp %h", pc, 32'h0040_0008); end
    jump = 1; branch = 1; branch_taken = 1; instr = 32'h0010_0040;
    step(); idle();
    if (DLY) step();
    nTests++; if (pc !== 32'h0040_0100) begin nFail++; $display("FAIL jump_priority: got %h exp %h", pc, 32'h0040_0100); end
  endtask

  task automatic test_jal_return();
    logic [31:0] la;
    gotoPc(32'h0040_0020);
    la = 32'h0040_0020 + LOFF;
    nTests++; if (link_addr !== la) begin nFail++; $display("FAIL link_addr: got %h exp %h", link_addr, la); end
    jump = 1; link = 1; instr = 32'h0010_0040;
    step(); idle();
    nTests++; if (ras_top !== la || ras_empty !== 1'b0) begin nFail++; $display("FAIL jal_push: top %h empty %b exp %h 0", ras_top, ras_empty, la); end
    if (DLY) step();
    nTests++; if (pc !== 32'h0040_0100) begin nFail++; $display("FAIL jal_target: got %h exp %h", pc, 32'h0040_0100); end
    jump = 1; jump_register = 1; is_return = 1; register_value = la;
    step(); idle();
    nTests++; if (ret_mispredict !== 1'b0 || ras_empty !== 1'b1) begin nFail++; $display("FAIL ret_ok: mis %b empty %b exp 0 1", ret_mispredict, ras_empty); end
    if (DLY) step();
    nTests++; if (pc !== la) begin nFail++; $display("FAIL ret_target: got %h exp %h", pc, la); end
    // wrong return target
    link = 1; step(); idle();
    jump = 1; jump_register = 1; is_return = 1; register_value = 32'h0040_0400;
    step(); idle();
    nTests++; if (ret_mispredict !== 1'b1) begin nFail++; $display("FAIL ret_wrong: mis %b exp 1", ret_mispredict); end
    step();
    nTests++; if (ret_mispredict !== 1'b0 || ras_empty !== 1'b1) begin nFail++; $display("FAIL ret_wrong_clear: mis %b empty %b exp 0 1", ret_mispredict, ras_empty); end
  endtask

  task automatic test_jalr_ra();
    logic [31:0] a, b;
    gotoPc(32'h0040_0300);
    a = 32'h0040_0300 + LOFF;
    b = 32'h0040_0304 + LOFF;
    link = 1; step(); idle();
    jump = 1; jump_register = 1; link = 1; is_return = 1; register_value = a;
    step(); idle();
    nTests++; if (ret_mispredict !== 1'b0 || ras_top !== b || ras_empty !== 1'b0) begin nFail++; $display("FAIL jalr_ra: mis %b top %h empty %b exp 0 %h 0", ret_mispredict, ras_top, ras_empty, b); end
    if (DLY) step();
    jump = 1; jump_register = 1; is_return = 1; register_value = b;
    step(); idle();
    nTests++; if (ret_mispredict !== 1'b0 || ras_empty !== 1'b1) begin nFail++; $display("FAIL jalr_ra_pop: mis %b empty %b exp 0 1", ret_mispredict, ras_empty); end
    if (DLY) step();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] pushed [5];
    gotoPc(32'h0040_0200);
    for (int i = 0; i < 5; i++) begin
      pushed[i] = 32'h0040_0200 + 32'(4*i) + LOFF;
      link = 1; step();
    end
    idle();
    nTests++; if (ras_top !== pushed[4] || ras_empty !== 1'b0) begin nFail++; $display("FAIL ovf_top: top %h empty %b exp %h 0", ras_top, ras_empty, pushed[4]); end
    for (int k = 0; k < 5; k++) begin
      jump = 1; jump_register = 1; is_return = 1; register_value = pushed[4-k];
      step(); idle();
      nTests++; if (ret_mispredict !== (k == 4)) begin nFail++; $display("FAIL ovf_pop%0d: mis %b exp %b", k, ret_mispredict, k == 4); end
      if (DLY) step();
    end
    nTests++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin nFail++; $display("FAIL ovf_empty: empty %b top %h exp 1 0", ras_empty, ras_top); end
  endtask

  task automatic test_misaligned();
    gotoPc(32'h0040_0040);
    jump = 1; jump_register = 1; register_value = 32'h0040_0103;
    step(); idle();
    nTests++; if (addr_misaligned !== 1'b1) begin nFail++; $display("FAIL misalign_pulse: got %b exp 1", addr_misaligned); end
    if (DLY) step();
    nTests++; if (pc !== 32'h0040_0100) begin nFail++; $display("FAIL misalign_pc: got %h exp %h", pc, 32'h0040_0100); end
    step();
    nTests++; if (addr_misaligned !== 1'b0 || pc !== 32'h0040_0104) begin nFail++; $display("FAIL misalign_clear: mis %b pc %h exp 0 %h", addr_misaligned, pc, 32'h0040_0104); end
  endtask

  task automatic test_stall_reset();
    logic [31:0] held;
    gotoPc(32'h0040_0010);
    branch = 1; branch_taken = 1; instr = 32'h0000_FFFC;
    step(); idle();
    held = DLY ? 32'h0040_0014 : 32'h0040_0004;
    stall = 1; jump = 1; link = 1; instr = 32'h0010_0080;
    for (int i = 0; i < 3; i++) begin
      step();
      nTests++; if (pc !== held || ras_empty !== 1'b1) begin nFail++; $display("FAIL stall%0d: pc %h empty %b exp %h 1", i, pc, ras_empty, held); end
    end
    idle(); step();
    nTests++; if (pc !== (DLY ? 32'h0040_0004 : 32'h0040_0008)) begin nFail++; $display("FAIL stall_release: got %h exp %h", pc, DLY ? 32'h0040_0004 : 32'h0040_0008); end
    branch = 1; branch_taken = 1; instr = 32'h0000_0040;
    step(); idle();
    rst_n = 0; #1;
    nTests++; if (pc !== 32'h0040_0000) begin nFail++; $display("FAIL async_reset: got %h exp %h", pc, 32'h0040_0000); end
    step();
    rst_n = 1;
    step();
    nTests++; if (pc !== 32'h0040_0004) begin nFail++; $display("FAIL post_reset: got %h exp %h", pc, 32'h0040_0004); end
  endtask

  initial begin
    idle();
    test_reset();
    test_branch();
    test_jal_return();
    test_jalr_ra();
    test_ras_overflow();
    test_misaligned();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS core's fetch stage. It owns the PC register and computes the next fetch address from branch, jump and jump-register controls. It also handles the optional branch delay slot and keeps a return-address stack (RAS) that checks `jr $ra` targets against predicted returns. It sits between the decoder/comparator outputs and instruction memory, and replaces the purely combinational next-instruction calculation.

## Interface
- `ADDR_W`, 32, PC/address width; must be ≥ 28.
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset (truncated to `ADDR_W`).
- `RAS_DEPTH`, 4, return-address stack entries; must be a power of two, ≥ 2.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: when 1, freeze all state; control inputs are ignored.
- `instr` in 32: instruction word at the current `pc`. Bits [15:0] are the branch immediate; bits [25:0] are the jump index.
- `branch` in 1: the current instruction is a conditional branch.
- `branch_taken` in 1: comparator result; valid with `branch`.
- `jump` in 1: the current instruction is j/jal/jr/jalr.
- `jump_register` in 1: with `jump`, the target comes from `register_value`.
- `register_value` in 32: rs value for jr/jalr; the low `ADDR_W` bits are used.
- `link` in 1: jal/jalr; push the return address onto the RAS.
- `is_return` in 1: jr with rs = $31; pop the RAS and compare.
- `pc` out ADDR_W: current fetch address.
- `pc_plus4` out ADDR_W: `pc` + 4.
- `link_addr` out ADDR_W: return address written to $31/rd.
- `ras_top` out ADDR_W: top RAS entry, or 0 when empty.
- `ras_empty` out 1: RAS holds no entries.
- `ret_mispredict` out 1: one-cycle pulse; return target ≠ popped RAS entry, or pop on empty.
- `addr_misaligned` out 1: one-cycle pulse; jr target bits [1:0] ≠ 0.

## Operation
- **Branch target:** `pc_plus4` + (sign-extend(`instr[15:0]`) << 2), computed modulo 2^ADDR_W.
- **Jump target:** {`pc_plus4[ADDR_W-1:28]`, `instr[25:0]`, 2'b00}.
- **jr target:** `register_value[ADDR_W-1:0]` with bits [1:0] forced to 0. Raise `addr_misaligned` if the original bits were nonzero.
- **Redirect:** `jump`, or `branch` with `branch_taken`. `jump` has priority over `branch` when both are asserted.
- **Link address:** `pc` + 8 with the delay slot enabled, `pc` + 4 without it; wraps modulo 2^ADDR_W.
- **State machine:** two states, NORMAL and DELAY. DELAY exists only with the delay slot enabled.
  - NORMAL + redirect → DELAY; `pc` ← `pc_plus4`; `pending` ← target.
  - DELAY → NORMAL; `pc` ← `pending`. All control inputs are ignored in DELAY, including `link` and `is_return`.
  - NORMAL, no redirect: `pc` ← `pc_plus4`.
- **RAS:** circular buffer plus a count that saturates at `RAS_DEPTH`.
  - `link` pushes `link_addr`. A push when full overwrites the oldest entry and the count stays at `RAS_DEPTH`.
  - `is_return` (meaningful only with `jump` and `jump_register`) pops the stack and compares the popped entry with the jr target. A mismatch pulses `ret_mispredict`.
  - Pop on empty: state unchanged, `ret_mispredict` pulses.
  - `link` and `is_return` together (jalr $31): pop/compare first, then push. The net count is unchanged and the top becomes the new `link_addr`.
- The redirect always uses the real target; the RAS is advisory only.

## Timing
- **Reset** (asynchronous, on `rst_n` = 0): `pc` = `RESET_PC`, state NORMAL, `pending` = 0, RAS count 0, `ras_top` = 0, `ras_empty` = 1, `ret_mispredict` = 0, `addr_misaligned` = 0.
- Reset mid-DELAY discards `pending`. The first fetch after reset is `RESET_PC`.
- `pc` updates on a rising edge with `stall` = 0. Control inputs are sampled on that same edge.
- `pc_plus4`, `link_addr` and `ras_top` are combinational from registered state.
- `ret_mispredict` and `addr_misaligned` are registered: they are high for exactly the cycle after the sampling edge and clear on the next edge.
- Under stall, pulses clear after one cycle and no new events are sampled.
- Redirect latency: target fetched 1 cycle after the sampling edge without the delay slot, 2 cycles with it.

## Configuration
- **`PC_SEQ_DELAY_SLOT_EN` defined:** MIPS delay slot behaviour. The FSM includes DELAY, link = `pc` + 8, redirect latency is 2.
- **Not defined:** no DELAY state and no `pending` register. A redirect loads the target on the sampling edge, link = `pc` + 4.

## Test plan
- **Reset:** reset with `RESET_PC`=0x00400000, no controls for 3 edges → `pc` sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
- **Backward branch:** `pc`=0x00400010, `branch`=1, `branch_taken`=1, `instr[15:0]`=0xFFFC → target 0x00400004. With the delay slot: 0x00400014 then 0x00400004. Without it: 0x00400004 next.
- **jal and return:** jal at 0x00400020, `instr[25:0]`=0x0100040 → target 0x00400100, `link_addr`=0x00400028 (delay slot) pushed, `ras_top`=0x00400028. Later jr $31 with `register_value`=0x00400028 → no mispredict, `ras_empty`=1.
- **RAS overflow:** 5 pushes with `RAS_DEPTH`=4, then 5 returns with matching targets → first 4 pops match, 5th pulses `ret_mispredict` (empty).
- **jr misalignment:** jr with `register_value`=0x00400103 → `pc` reaches 0x00400100, `addr_misaligned` high for one cycle.
- **Stall and reset:** stall asserted during DELAY for 3 cycles → `pc` held and `pending` kept. Then `rst_n` pulse mid-DELAY → `pc`=0x00400000, state NORMAL.
